// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// One request channel (valid/ready/addr) and one response channel
// (valid/data, no backpressure). The fetch stage uses the master modport,
// the memory (or its model) the slave modport.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline.
// Holds the PC, issues one instruction-memory request at a time and drives
// the IF/ID pipeline register. A response that lands while decode is stalled
// is parked in a 1-entry skid buffer. An EX redirect flushes IF/ID and the
// buffer and, if a request is still in flight, marks its response to be
// dropped (kill).
// Optional: define FETCH_PERF_CNT_EN to add redirect/stall cycle counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pc_en,
  input  logic                 modify_pc_ex,
  input  logic [XLEN-1:0]      pc_target_ex,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [XLEN-1:0]      if_id_pc,
  output logic [XLEN-1:0]      if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_redirect_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

  logic            req_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            deliver;

  // Handshake qualifiers shared by the FSM, PC and IF/ID logic.
  always_comb begin
    req_valid = (state_q == REQ) && !buf_valid_q && !modify_pc_ex;
    req_fire  = req_valid && imem.imem_req_ready;
    rsp_fire  = (state_q == WAIT) && imem.imem_rsp_valid;
    // A response is only useful if it was not killed by an earlier redirect
    // and no redirect is arriving in the same cycle.
    deliver   = rsp_fire && !kill_q && !modify_pc_ex;
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc_q;

  // FSM next-state: REQ issues, WAIT holds until the single response returns.
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    req_pc_d = req_pc_q;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          // Response consumed (delivered or dropped); any kill is spent.
          state_d = REQ;
          kill_d  = 1'b0;
        end else if (modify_pc_ex) begin
          // In-flight request now fetches a wrong-path instruction.
          kill_d = 1'b1;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Next PC: redirect wins, otherwise advance by one word on each accepted request.
  always_comb begin
    pc_d = pc_q;
    if (modify_pc_ex) begin
      pc_d = pc_target_ex;
    end else if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // IF/ID register and skid buffer: flush on redirect, drain/advance when
  // enabled, park a delivery in the buffer while stalled.
  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (modify_pc_ex) begin
      ifid_valid_d = 1'b0;
      buf_valid_d  = 1'b0;
    end else if (pc_en) begin
      if (buf_valid_q) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = buf_pc_q;
        ifid_instr_d = buf_instr_q;
        buf_valid_d  = 1'b0;
      end else if (deliver) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = req_pc_q;
        ifid_instr_d = imem.imem_rsp_data;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end else if (deliver) begin
      // Requests are blocked while the buffer is full, so it is empty here.
      buf_valid_d = 1'b1;
      buf_pc_d    = req_pc_q;
      buf_instr_d = imem.imem_rsp_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_pc_q     <= '0;
      buf_instr_q  <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      buf_valid_q  <= buf_valid_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign if_id_valid = ifid_valid_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_instr = ifid_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redir_cnt_q, redir_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Cycle counters; a redirect cycle is never also counted as a stall.
  always_comb begin
    redir_cnt_d = redir_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (modify_pc_ex) begin
      redir_cnt_d = redir_cnt_q + 32'd1;
    end else if (!pc_en) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_redirect_cnt = redir_cnt_q;
  assign perf_stall_cnt    = stall_cnt_q;
`endif

endmodule
